// File: rtl/cdb_pkg.sv
// Shared CDB definitions: sizes, tag type and the
// lowest-index-first grant rule used by the CDB arbiter.
package cdb_pkg;

  localparam int NUM_FU          = 5;
  localparam int SUPERSCALAR_WAY = 2;
  localparam int PHY_REG_NUM     = 8;
  localparam int TAG_W           = $clog2(PHY_REG_NUM);

  typedef logic [TAG_W-1:0] phy_tag_t;

  function automatic logic [NUM_FU-1:0] cdb_grant(
    input logic [NUM_FU-1:0] req
  );
    logic [NUM_FU-1:0] g;
    int                n;
    g = '0;
    n = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (req[i] && (n < SUPERSCALAR_WAY)) begin
        g[i] = 1'b1;
      end
      if (req[i]) begin
        n = n + 1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/complete_fifo.sv
// Single-FU completion FIFO: valid/ready push, pop on grant, flush.
// Ports: clk, reset, flush_i, valid_i, tag_i, pop_i -> ready_o, req_o, head_o.
module complete_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_i,
  input  logic     valid_i,
  input  phy_tag_t tag_i,
  input  logic     pop_i,
  output logic     ready_o,
  output logic     req_o,
  output phy_tag_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  phy_tag_t           mem_q [DEPTH];
  phy_tag_t           mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;

  assign ready_o = (count_q < CNT_W'(DEPTH));
  assign req_o   = (count_q != '0);
  assign head_o  = req_o ? mem_q[rd_ptr_q] : '0;

  // Pop is only meaningful when non-empty; grant already implies that.
  assign push = valid_i && ready_o && !flush_i;
  assign pop  = pop_i && req_o && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = tag_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU completion buffers feeding the CDB; pops what the CDB grants.
// Ports: fu_valid_i/fu_tag_i in, fu_ready_o, cdb_req_o, cdb_tag_o out.
module fu_complete_buffer
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic     [NUM_FU-1:0] fu_valid_i,
  input  phy_tag_t [NUM_FU-1:0] fu_tag_i,
  output logic     [NUM_FU-1:0] fu_ready_o,
  output logic     [NUM_FU-1:0] cdb_req_o,
  output phy_tag_t [NUM_FU-1:0] cdb_tag_o
);

  logic [NUM_FU-1:0] grant;

  // Same rule the CDB applies, so popped == broadcast.
  assign grant = cdb_grant(cdb_req_o);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    complete_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush_i),
      .valid_i (fu_valid_i[i]),
      .tag_i   (fu_tag_i[i]),
      .pop_i   (grant[i]),
      .ready_o (fu_ready_o[i]),
      .req_o   (cdb_req_o[i]),
      .head_o  (cdb_tag_o[i])
    );
  end

endmodule
